// File: rtl/seq_ext_pkg.sv
// Shared definitions for the serial sync-word extractor.
// Contents:
//   ST_HUNT / ST_PAYLOAD : state encodings (state_e uses them as its values)
//   clog2()              : constant function used to size the bit/history counters
package seq_ext_pkg;

    localparam logic ST_HUNT    = 1'b0;
    localparam logic ST_PAYLOAD = 1'b1;

    typedef enum logic {
        HUNT    = ST_HUNT,
        PAYLOAD = ST_PAYLOAD
    } state_e;

    // Ceiling log2. It returns 0 for an input of 1, so callers that need at
    // least one bit must clamp the result themselves.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_extract_if.sv
// Bus bundle between a serial line receiver / control logic and seq_extract.
// Signals:
//   din, din_vld        serial bit and its qualifier (driven by master)
//   cfg_en, cfg_pat     block enable and sync word (driven by master)
//   dout, dout_vld      captured payload word and its one-cycle strobe
//   sync_hit            one-cycle strobe on a sync word match
//   busy                high while payload bits are being captured
//   frame_cnt           saturating count of completed frames
// Modports: master = stimulus/control side, slave = the extractor.
interface seq_extract_if #(
    parameter int SYNC_W    = 8,
    parameter int PAYLOAD_W = 8,
    parameter int CNT_W     = 8
);
    logic                 din;
    logic                 din_vld;
    logic                 cfg_en;
    logic [SYNC_W-1:0]    cfg_pat;
    logic [PAYLOAD_W-1:0] dout;
    logic                 dout_vld;
    logic                 sync_hit;
    logic                 busy;
    logic [CNT_W-1:0]     frame_cnt;

    modport master (
        output din, din_vld, cfg_en, cfg_pat,
        input  dout, dout_vld, sync_hit, busy, frame_cnt
    );

    modport slave (
        input  din, din_vld, cfg_en, cfg_pat,
        output dout, dout_vld, sync_hit, busy, frame_cnt
    );
endinterface

// File: rtl/seq_match.sv
// Sync word history and comparator.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   clr          empty the history (takes priority over shift_en)
//   shift_en     accept din into the history this cycle
//   din          serial bit
//   pat          sync word, MSB = oldest bit
//   hit          combinational: the history as it will be after this shift
//                holds SYNC_W real bits equal to pat
module seq_match
    import seq_ext_pkg::*;
#(
    parameter int SYNC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              din,
    input  logic [SYNC_W-1:0] pat,
    output logic              hit
);
    localparam int HW = clog2(SYNC_W + 1);
    localparam logic [HW-1:0] HIST_FULL = HW'(SYNC_W);

    logic [SYNC_W-1:0] shreg_q, shreg_d;
    logic [HW-1:0]     hist_cnt_q, hist_cnt_d;

    assign shreg_d    = {shreg_q[SYNC_W-2:0], din};
    assign hist_cnt_d = (hist_cnt_q == HIST_FULL) ? hist_cnt_q : hist_cnt_q + HW'(1);

    // hist_cnt guards against matching on reset/cleared zeros, e.g. an
    // all-zero pattern needs SYNC_W genuinely received zeros.
    assign hit = shift_en && (hist_cnt_d == HIST_FULL) && (shreg_d == pat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q    <= '0;
            hist_cnt_q <= '0;
        end else if (clr) begin
            shreg_q    <= '0;
            hist_cnt_q <= '0;
        end else if (shift_en) begin
            shreg_q    <= shreg_d;
            hist_cnt_q <= hist_cnt_d;
        end
    end
endmodule

// File: rtl/seq_extract.sv
// Serial sync-word hunter and payload extractor.
// Hunts the din stream for cfg_pat; after a match it captures the next
// PAYLOAD_W bits MSB-first and presents them on dout with a dout_vld pulse.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          seq_extract_if slave: din/din_vld/cfg_en/cfg_pat in,
//                dout/dout_vld/sync_hit/busy/frame_cnt out (all registered)
module seq_extract
    import seq_ext_pkg::*;
#(
    parameter int SYNC_W    = 8,
    parameter int PAYLOAD_W = 8,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    seq_extract_if.slave bus
);
    localparam int BCW = (clog2(PAYLOAD_W) < 1) ? 1 : clog2(PAYLOAD_W);
    localparam logic [BCW-1:0] BC_LAST = BCW'(PAYLOAD_W - 1);

    state_e               state_q, state_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_W-1:0] pay_q, pay_d;
    logic [PAYLOAD_W-1:0] dout_q, dout_d;
    logic                 dout_vld_q, dout_vld_d;
    logic                 sync_hit_q, sync_hit_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;

    logic                 hist_clr;
    logic                 hist_shift;
    logic                 hit;
    logic [PAYLOAD_W-1:0] pay_shift;

    seq_match #(
        .SYNC_W (SYNC_W)
    ) u_match (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (hist_clr),
        .shift_en (hist_shift),
        .din      (bus.din),
        .pat      (bus.cfg_pat),
        .hit      (hit)
    );

    // Payload register with the incoming bit appended at the LSB end.
    generate
        if (PAYLOAD_W == 1) begin : g_pay_one
            assign pay_shift = bus.din;
        end else begin : g_pay_many
            assign pay_shift = {pay_q[PAYLOAD_W-2:0], bus.din};
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        pay_d       = pay_q;
        dout_d      = dout_q;
        dout_vld_d  = 1'b0;
        sync_hit_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;
        hist_clr    = 1'b0;
        hist_shift  = 1'b0;

        // Disable wins over data: abandon any frame and restart from an
        // empty history; dout and frame_cnt are left untouched.
        if (!bus.cfg_en) begin
            state_d   = HUNT;
            bit_cnt_d = '0;
            pay_d     = '0;
            hist_clr  = 1'b1;
        end else if (bus.din_vld) begin
            case (state_q)
                HUNT: begin
                    hist_shift = 1'b1;
                    if (hit) begin
                        sync_hit_d = 1'b1;
                        state_d    = PAYLOAD;
                        bit_cnt_d  = '0;
                        pay_d      = '0;
                    end
                end
                PAYLOAD: begin
                    // History is frozen here and wiped at frame end so that
                    // payload bits can never form part of the next sync word.
                    pay_d = pay_shift;
                    if (bit_cnt_q == BC_LAST) begin
                        dout_d     = pay_shift;
                        dout_vld_d = 1'b1;
                        if (!(&frame_cnt_q)) begin
                            frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        end
                        state_d   = HUNT;
                        bit_cnt_d = '0;
                        hist_clr  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            bit_cnt_q   <= '0;
            pay_q       <= '0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            sync_hit_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pay_q       <= pay_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            sync_hit_q  <= sync_hit_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.sync_hit  = sync_hit_q;
    assign bus.busy      = (state_q == PAYLOAD);
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_seq_extract.sv
module tb_seq_extract;
    localparam int SYNC_W    = 4;
    localparam int PAYLOAD_W = 4;
    localparam int CNT_W     = 2;
    localparam int OW        = PAYLOAD_W + 3 + CNT_W;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    seq_extract_if #(.SYNC_W(SYNC_W), .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)) bus ();

    seq_extract #(.SYNC_W(SYNC_W), .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: received bits kept as plain lists.
    bit                   m_in_payload;
    bit                   m_hist[$];
    bit                   m_pay[$];
    logic [PAYLOAD_W-1:0] m_dout;
    logic                 m_dv;
    logic                 m_sh;
    int                   m_fc;

    task automatic model_reset();
        m_in_payload = 0;
        m_hist.delete();
        m_pay.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_sh   = 1'b0;
        m_fc   = 0;
    endtask

    task automatic model_step(input bit e, input bit v, input bit d);
        logic [SYNC_W-1:0]    w;
        logic [PAYLOAD_W-1:0] p;
        m_dv = 1'b0;
        m_sh = 1'b0;
        if (!e) begin
            m_in_payload = 0;
            m_hist.delete();
            m_pay.delete();
        end else if (v) begin
            if (!m_in_payload) begin
                m_hist.push_back(d);
                if (m_hist.size() > SYNC_W) void'(m_hist.pop_front());
                w = '0;
                foreach (m_hist[k]) w = {w[SYNC_W-2:0], logic'(m_hist[k])};
                if (m_hist.size() == SYNC_W && w == bus.cfg_pat) begin
                    m_sh = 1'b1;
                    m_in_payload = 1;
                    m_pay.delete();
                end
            end else begin
                m_pay.push_back(d);
                if (m_pay.size() == PAYLOAD_W) begin
                    p = '0;
                    foreach (m_pay[k]) p = {p[PAYLOAD_W-2:0], logic'(m_pay[k])};
                    m_dout = p;
                    m_dv   = 1'b1;
                    if (m_fc < (1 << CNT_W) - 1) m_fc++;
                    m_in_payload = 0;
                    m_hist.delete();
                end
            end
        end
    endtask

    function automatic logic [OW-1:0] exp_vec();
        return {m_dout, m_dv, m_sh, logic'(m_in_payload), CNT_W'(m_fc)};
    endfunction

    function automatic logic [OW-1:0] obs_vec();
        return {bus.dout, bus.dout_vld, bus.sync_hit, bus.busy, bus.frame_cnt};
    endfunction

    // Drive one cycle of inputs, let the model take the same edge, then
    // settle 1 time unit past the edge for sampling.
    task automatic step(input bit d, input bit v, input bit e);
        bus.din     = d;
        bus.din_vld = v;
        bus.cfg_en  = e;
        @(posedge clk);
        model_step(e, v, d);
        #1;
    endtask

    task automatic do_reset();
        bus.din_vld = 1'b0;
        bus.cfg_en  = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.din      = 1'b0;
        bus.din_vld  = 1'b0;
        bus.cfg_en   = 1'b1;
        bus.cfg_pat  = 4'b1011;
        model_reset();
        @(posedge clk);
        #1;
        n_tests++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", obs_vec(), '0);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_basic();
        logic [7:0] s;
        s = 8'b1011_0110;
        for (int i = 7; i >= 0; i--) begin
            step(s[i], 1'b1, 1'b1);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL basic_bit%0d: got %h expected %h", 7 - i, obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if (bus.dout !== 4'b0110 || bus.frame_cnt !== 2'd1 || bus.dout_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_word: got dout=%b cnt=%0d vld=%b expected dout=0110 cnt=1 vld=1",
                     bus.dout, bus.frame_cnt, bus.dout_vld);
        end
    endtask

    task automatic test_overlap();
        logic [9:0] s;
        int hits;
        s = 10'b101011_1111;
        hits = 0;
        for (int i = 9; i >= 0; i--) begin
            step(s[i], 1'b1, 1'b1);
            if (bus.sync_hit === 1'b1) hits++;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL overlap_bit%0d: got %h expected %h", 9 - i, obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if (hits != 1 || bus.dout !== 4'b1111) begin
            n_fail++;
            $display("FAIL overlap_word: got hits=%0d dout=%b expected hits=1 dout=1111", hits, bus.dout);
        end
    endtask

    task automatic test_stall();
        logic [7:0] s;
        int sh_cnt;
        int dv_cnt;
        s = 8'b1011_0110;
        sh_cnt = 0;
        dv_cnt = 0;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            step(s[i], 1'b1, 1'b1);
            if (bus.sync_hit === 1'b1) sh_cnt++;
            if (bus.dout_vld === 1'b1) dv_cnt++;
            for (int g = 0; g < 3; g++) begin
                step(1'b1, 1'b0, 1'b1);
                if (bus.sync_hit === 1'b1) sh_cnt++;
                if (bus.dout_vld === 1'b1) dv_cnt++;
                n_tests++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL stall_gap%0d_%0d: got %h expected %h", 7 - i, g, obs_vec(), exp_vec());
                end
            end
        end
        n_tests++;
        if (sh_cnt != 1 || dv_cnt != 1 || bus.dout !== 4'b0110 || bus.frame_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL stall_summary: got sh=%0d dv=%0d dout=%b cnt=%0d expected sh=1 dv=1 dout=0110 cnt=1",
                     sh_cnt, dv_cnt, bus.dout, bus.frame_cnt);
        end
    endtask

    task automatic test_stale();
        bus.cfg_pat = 4'b0000;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
            n_tests++;
            if (bus.sync_hit !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stale_zero%0d: got sync_hit=%b expected 0", i, bus.sync_hit);
            end
        end
        step(1'b0, 1'b1, 1'b1);
        n_tests++;
        if (bus.sync_hit !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stale_fourth: got sync_hit=%b busy=%b expected 1 1", bus.sync_hit, bus.busy);
        end
    endtask

    task automatic test_abort();
        logic [5:0]  pre;
        logic [3:0]  post;
        logic [7:0]  good;
        int dv_cnt;
        pre  = 6'b1011_01;
        post = 4'b0110;
        good = 8'b1011_1001;
        dv_cnt = 0;
        bus.cfg_pat = 4'b1011;
        do_reset();
        for (int i = 5; i >= 0; i--) step(pre[i], 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (obs_vec() !== exp_vec() || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_disable: got %h expected %h", obs_vec(), exp_vec());
        end
        for (int i = 3; i >= 0; i--) begin
            step(post[i], 1'b1, 1'b1);
            if (bus.dout_vld === 1'b1) dv_cnt++;
        end
        n_tests++;
        if (dv_cnt != 0 || bus.frame_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL abort_nodata: got dv=%0d cnt=%0d expected dv=0 cnt=0", dv_cnt, bus.frame_cnt);
        end
        for (int i = 7; i >= 0; i--) step(good[i], 1'b1, 1'b1);
        n_tests++;
        if (bus.dout_vld !== 1'b1 || bus.dout !== 4'b1001 || bus.frame_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL abort_recover: got vld=%b dout=%b cnt=%0d expected vld=1 dout=1001 cnt=1",
                     bus.dout_vld, bus.dout, bus.frame_cnt);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt[5];
        logic [3:0] sync;
        logic [3:0] pay;
        exp_cnt = '{1, 2, 3, 3, 3};
        sync = 4'b1011;
        do_reset();
        for (int f = 0; f < 5; f++) begin
            pay = 4'($urandom);
            for (int i = 3; i >= 0; i--) step(sync[i], 1'b1, 1'b1);
            for (int i = 3; i >= 0; i--) step(pay[i], 1'b1, 1'b1);
            n_tests++;
            if (bus.frame_cnt !== 2'(exp_cnt[f]) || bus.dout !== pay || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL sat_frame%0d: got cnt=%0d dout=%b expected cnt=%0d dout=%b",
                         f, bus.frame_cnt, bus.dout, exp_cnt[f], pay);
            end
        end
        for (int i = 3; i >= 0; i--) step(sync[i], 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", obs_vec(), '0);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic test_random();
        bit d;
        bit v;
        bit e;
        int errs;
        errs = 0;
        for (int c = 0; c < 1500; c++) begin
            d = bit'($urandom_range(0, 1));
            v = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 49) != 0);
            if (c % 150 == 0) begin
                e = 1'b0;
                bus.cfg_pat = 4'($urandom);
            end
            step(d, v, e);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_overlap();
        test_stall();
        test_stale();
        test_abort();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
